mem_arbiter: RTL

Parametrised round-robin arbiter that shares one single-port synchronous data RAM (DRAM) between NUM_CH processor cores. It sits between the cores' data-memory ports and the DRAM instance in the top level. It issues one access per cycle on behalf of a single owner and drives each core's `acq` stall input. It generalises the two-core memory controller to any channel count, width and depth. It adds bounded burst ownership and tagged, registered read return.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/rr_picker.sv | 35 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the multi-core data-RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int unsigned MIN_IDX_W = 1;

  // Index width for n items; a single item still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n > 1) return unsigned'($clog2(n));
    return MIN_IDX_W;
  endfunction

  // Low bit of slice i in a packed per-channel bus of w-bit slices.
  function automatic int unsigned slice_lo(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after start, with wrap.
module rr_picker #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  start,
  output logic              found,
  output logic [IDX_W-1:0]  grant
);

  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        if (i >= int'(start)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign found = |req;
  assign grant = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between NUM_CH cores,
// with bounded burst ownership and tagged, registered read return.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        rden,
  input  logic [NUM_CH-1:0]        wren,
  input  logic [NUM_CH*ADDR_W-1:0] Address,
  input  logic [NUM_CH*DATA_W-1:0] Din,
  output logic [NUM_CH-1:0]        acq,
  output logic [NUM_CH*DATA_W-1:0] Dq,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [ADDR_W-1:0]        RAMAddress,
  output logic [DATA_W-1:0]        RAMDin,
  output logic                     RAMwren,
  input  logic [DATA_W-1:0]        RAMq
);

  localparam int unsigned IDX_W = idx_w(NUM_CH);
  localparam int unsigned CNT_W = idx_w(MAX_BURST);

  state_t           state, state_n;
  logic [IDX_W-1:0] owner, owner_n, owner_inc, rr, rr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_CH-1:0] req, acq_n, pick_req;
  logic [IDX_W-1:0] pick_start, pick_grant;
  logic             pick_found;
  logic             rd_push;

  logic [ADDR_W-1:0] addr_ch [NUM_CH];
  logic [DATA_W-1:0] din_ch  [NUM_CH];
  logic [DATA_W-1:0] dq_r    [NUM_CH];
  logic              pipe_v  [RD_LAT];
  logic [IDX_W-1:0]  pipe_ch [RD_LAT];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    assign addr_ch[g] = Address[slice_lo(g, ADDR_W) +: ADDR_W];
    assign din_ch[g]  = Din[slice_lo(g, DATA_W) +: DATA_W];
    assign Dq[slice_lo(g, DATA_W) +: DATA_W] = dq_r[g];
  end

  assign req       = rden | wren;
  assign owner_inc = (owner == IDX_W'(NUM_CH - 1)) ? '0 : owner + IDX_W'(1);

  // From IDLE search from rr; while owning, search the other channels starting after the owner.
  always_comb begin
    pick_req   = req;
    pick_start = rr;
    if (state == OWN) begin
      pick_req   = req & ~(NUM_CH'(1) << owner);
      pick_start = owner_inc;
    end
  end

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .grant (pick_grant)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    rr_n    = rr;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = OWN;
          owner_n = pick_grant;
          cnt_n   = '0;
        end
      end
      OWN: begin
        if (req[owner] && (cnt < CNT_W'(MAX_BURST - 1))) begin
          cnt_n = cnt + CNT_W'(1);
        end else if (pick_found) begin
          owner_n = pick_grant;
          cnt_n   = '0;
          rr_n    = owner_inc;
        end else if (req[owner]) begin
          cnt_n = '0;
        end else begin
          state_n = IDLE;
          rr_n    = owner_inc;
        end
      end
      default: state_n = IDLE;
    endcase
    acq_n = (state_n == OWN) ? (NUM_CH'(1) << owner_n) : '0;
  end

  // RAM port follows the current owner; a write wins over a simultaneous read.
  assign RAMwren    = (state == OWN) && wren[owner];
  assign RAMAddress = (state == OWN) ? addr_ch[owner] : '0;
  assign RAMDin     = (state == OWN) ? din_ch[owner] : '0;
  assign rd_push    = (state == OWN) && rden[owner] && !wren[owner];

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= '0;
      cnt    <= '0;
      rr     <= '0;
      acq    <= '0;
      rvalid <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) dq_r[i] <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        pipe_v[k]  <= 1'b0;
        pipe_ch[k] <= '0;
      end
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      cnt        <= cnt_n;
      rr         <= rr_n;
      acq        <= acq_n;
      pipe_v[0]  <= rd_push;
      pipe_ch[0] <= owner;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_ch[k] <= pipe_ch[k-1];
      end
      rvalid <= '0;
      if (pipe_v[RD_LAT-1]) begin
        rvalid[pipe_ch[RD_LAT-1]] <= 1'b1;
        dq_r[pipe_ch[RD_LAT-1]]   <= RAMq;
      end
    end
  end

endmodule
